// File: rtl/xor_encrypter_pkg.sv
// xor_encrypter_pkg
// Shared definitions for the byte-stream XOR cipher:
//   DATA_W_DEF / SHIFT_W_DEF : default datapath and rotate-amount widths
//   state_t                  : stream FSM states IDLE, RUN, DONE
//   rotl()                   : left-rotate helper at the default width
package xor_encrypter_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int SHIFT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Rotating a doubled copy left and keeping the upper half makes the bits
  // leaving the MSB reappear at the LSB without any modulo arithmetic.
  function automatic logic [DATA_W_DEF-1:0] rotl(
    input logic [DATA_W_DEF-1:0]  value,
    input logic [SHIFT_W_DEF-1:0] amount
  );
    logic [2*DATA_W_DEF-1:0] dbl;
    dbl = {value, value} << amount;
    return dbl[2*DATA_W_DEF-1:DATA_W_DEF];
  endfunction

endpackage

// File: rtl/xor_encrypter_unit_key_rotator.sv
// key_rotator
// Combinational barrel rotate of the cipher key.
// Ports:
//   key   in  DATA_W   key to rotate
//   shift in  SHIFT_W  left-rotate amount, 0..DATA_W-1
//   rk    out DATA_W   rotl(key, shift)
module key_rotator #(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 3
) (
  input  logic [DATA_W-1:0]  key,
  input  logic [SHIFT_W-1:0] shift,
  output logic [DATA_W-1:0]  rk
);

  logic [DATA_W-1:0] rot_unused_lo;

  // Upper half of the shifted doubled key is the rotated key.
  assign {rk, rot_unused_lo} = {key, key} << shift;

endmodule

// File: rtl/xor_encrypter_unit.sv
// xor_encrypter_unit
// Byte-stream XOR cipher: each enabled cycle din is XORed with the rotated
// key (and, in chained mode, the previous ciphertext) and registered on dout.
// Optional feature macro: IMPROVED_ENCRYPT_EN enables chained mode; without
// it improved_encrypt_enable is ignored and the chain register reads as 0.
// Ports:
//   clk                     in   system clock, rising edge
//   start_reset_n           in   asynchronous active-low reset
//   shift                   in   key left-rotate amount
//   key                     in   cipher key, sampled every enabled cycle
//   din                     in   plaintext byte
//   xor_enable              in   encrypt din this cycle
//   improved_encrypt_enable in   select chained mode (feature build only)
//   last_data               in   enabled byte this cycle is the final one
//   dout                    out  registered ciphertext
//   led_complete            out  stream finished (held until reset)
module xor_encrypter_unit
  import xor_encrypter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk,
  input  logic               start_reset_n,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [DATA_W-1:0]  key,
  input  logic [DATA_W-1:0]  din,
  input  logic               xor_enable,
  input  logic               improved_encrypt_enable,
  input  logic               last_data,
  output logic [DATA_W-1:0]  dout,
  output logic               led_complete
);

  state_t            state;
  logic [DATA_W-1:0] rk_p0;
  logic [DATA_W-1:0] c_p0;
  logic [DATA_W-1:0] chain_q;
  logic [DATA_W-1:0] dout_p1;
  logic              chain_sel_p0;
  logic              consume_p0;

  key_rotator #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_key_rotator (
    .key   (key),
    .shift (shift),
    .rk    (rk_p0)
  );

`ifdef IMPROVED_ENCRYPT_EN
  assign chain_sel_p0 = improved_encrypt_enable;
`else
  logic mode_unused;
  assign mode_unused  = improved_encrypt_enable;
  assign chain_sel_p0 = 1'b0;
  assign chain_q      = '0;
`endif

  // Stage p0: combinational cipher byte
  assign c_p0       = din ^ rk_p0 ^ (chain_sel_p0 ? chain_q : '0);
  assign consume_p0 = xor_enable && (state != DONE);

  // Stage p1: FSM plus dout / chain / completion registers
  always_ff @(posedge clk or negedge start_reset_n) begin
    if (!start_reset_n) begin
      state        <= IDLE;
      dout_p1      <= '0;
      led_complete <= 1'b0;
`ifdef IMPROVED_ENCRYPT_EN
      chain_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE, RUN: begin
          if (consume_p0) begin
            dout_p1 <= c_p0;
`ifdef IMPROVED_ENCRYPT_EN
            if (chain_sel_p0) chain_q <= c_p0;
`endif
            if (last_data) begin
              state        <= DONE;
              led_complete <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            // A gap in the stream pauses; chain_q is kept for the resume.
            state <= IDLE;
          end
        end
        // DONE is sticky: everything frozen until reset.
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dout = dout_p1;

endmodule

// File: tb/tb_xor_encrypter_unit.sv
module tb_xor_encrypter_unit;
  import xor_encrypter_pkg::*;

  logic       clk = 1'b0;
  logic       start_reset_n;
  logic [2:0] shift;
  logic [7:0] key;
  logic [7:0] din;
  logic       xor_enable;
  logic       improved_encrypt_enable;
  logic       last_data;
  logic [7:0] dout;
  logic       led_complete;

  int n_cmp = 0;
  int n_err = 0;

`ifdef IMPROVED_ENCRYPT_EN
  localparam logic [7:0] EXP_CH2    = 8'h00;
  localparam logic [7:0] EXP_RESUME = 8'hF0;
  localparam logic [7:0] EXP_RECHN  = 8'h58;
`else
  localparam logic [7:0] EXP_CH2    = 8'h57;
  localparam logic [7:0] EXP_RESUME = 8'hA7;
  localparam logic [7:0] EXP_RECHN  = 8'hA8;
`endif

  xor_encrypter_unit dut (
    .clk                     (clk),
    .start_reset_n           (start_reset_n),
    .shift                   (shift),
    .key                     (key),
    .din                     (din),
    .xor_enable              (xor_enable),
    .improved_encrypt_enable (improved_encrypt_enable),
    .last_data               (last_data),
    .dout                    (dout),
    .led_complete            (led_complete)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp_d, input logic exp_l);
    chk({tag, "_dout"}, dout, exp_d);
    chk({tag, "_led"}, {7'd0, led_complete}, {7'd0, exp_l});
  endtask

  task automatic enc(input logic [7:0] d, input logic [7:0] k, input logic [2:0] s,
                     input logic imp, input logic last);
    din = d; key = k; shift = s; improved_encrypt_enable = imp;
    last_data = last; xor_enable = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    xor_enable = 1'b0; last_data = 1'b0; improved_encrypt_enable = 1'b0;
    start_reset_n = 1'b0;
    tick();
    start_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset with random inputs
    start_reset_n = 1'b0;
    din = 8'($urandom); key = 8'($urandom); shift = 3'($urandom);
    xor_enable = 1'b1; improved_encrypt_enable = 1'b1; last_data = 1'b1;
    tick(); tick();
    chk_out("reset", 8'h00, 1'b0);

    xor_enable = 1'b0; last_data = 1'b0; improved_encrypt_enable = 1'b0;
    start_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("idle_after_reset", 8'h00, 1'b0);
    end

    // last_data without xor_enable does nothing
    last_data = 1'b1;
    tick();
    chk_out("last_without_en", 8'h00, 1'b0);

    // Simple sweep of rotate amounts
    enc(8'hFF, 8'hA8, 3'd0, 1'b0, 1'b0); chk_out("sweep_s0", 8'h57, 1'b0);
    enc(8'hFF, 8'hA8, 3'd1, 1'b0, 1'b0); chk_out("sweep_s1", 8'hAE, 1'b0);
    enc(8'hFF, 8'hA8, 3'd2, 1'b0, 1'b0); chk_out("sweep_s2", 8'h5D, 1'b0);
    enc(8'hFF, 8'hA8, 3'd3, 1'b0, 1'b0); chk_out("sweep_s3", 8'hBA, 1'b0);
    enc(8'hFF, 8'hA8, 3'd7, 1'b0, 1'b1); chk_out("sweep_s7_last", 8'hAB, 1'b1);

    // DONE is frozen
    enc(8'h12, 8'h34, 3'd5, 1'b0, 1'b0); chk_out("done_hold1", 8'hAB, 1'b1);
    enc(8'h9C, 8'h0F, 3'd2, 1'b1, 1'b1); chk_out("done_hold2", 8'hAB, 1'b1);

    // Chained pair
    do_reset();
    chk_out("reset2", 8'h00, 1'b0);
    enc(8'hFF, 8'hA8, 3'd0, 1'b1, 1'b0); chk_out("chain1", 8'h57, 1'b0);
    enc(8'hFF, 8'hA8, 3'd0, 1'b1, 1'b0); chk_out("chain2", EXP_CH2, 1'b0);

    // Pause / resume keeps chain state
    do_reset();
    enc(8'hFF, 8'hA8, 3'd0, 1'b1, 1'b0); chk_out("pause_first", 8'h57, 1'b0);
    xor_enable = 1'b0;
    din = 8'h33; key = 8'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("pause_hold", 8'h57, 1'b0);
    end
    enc(8'h0F, 8'hA8, 3'd0, 1'b1, 1'b0); chk_out("resume", EXP_RESUME, 1'b0);
    // Simple byte does not disturb chain_q; chaining picks it back up
    enc(8'h00, 8'hA8, 3'd0, 1'b0, 1'b0); chk_out("simple_mid", 8'hA8, 1'b0);
    enc(8'h00, 8'hA8, 3'd0, 1'b1, 1'b0); chk_out("rechain", EXP_RECHN, 1'b0);

    // Asynchronous reset mid-stream, between clock edges
    #3;
    start_reset_n = 1'b0;
    #1;
    chk_out("async_reset", 8'h00, 1'b0);
    chk("async_state", {6'd0, dut.state}, {6'd0, IDLE});
    xor_enable = 1'b0;
    #2;
    start_reset_n = 1'b1;
    tick();
    chk_out("post_async_idle", 8'h00, 1'b0);
    // chain_q cleared by reset: first chained byte sees zero chain
    enc(8'hFF, 8'hA8, 3'd0, 1'b1, 1'b0); chk_out("post_async_enc", 8'h57, 1'b0);
    enc(8'h5A, 8'h01, 3'd4, 1'b0, 1'b1); chk_out("post_async_last", 8'h4A, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xor_encrypter_unit.md
Name: xor_encrypter_unit

Overview:
Byte-stream XOR cipher for the DEA datapath.
- Each enabled clock, one plaintext byte din is XORed with a rotated 8-bit key and registered onto dout.
- An optional chained ("improved") mode also folds in the previous ciphertext byte.
- led_complete flags the end of the stream once the last byte has been encrypted.

Parameters:
DATA_W, 8, width of din, key, dout and the chain register.
SHIFT_W, 3, width of shift; must equal log2(DATA_W).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
start_reset_n  in  1  asynchronous, active-low reset; clears all state.
shift  in  SHIFT_W  key left-rotate amount, 0..DATA_W-1.
key  in  DATA_W  cipher key; sampled live every enabled cycle.
din  in  DATA_W  plaintext byte.
xor_enable  in  1  encrypt din this cycle.
improved_encrypt_enable  in  1  select chained mode; ignored unless the optional feature is built.
last_data  in  1  the byte presented with xor_enable=1 this cycle is the final one.
dout  out  DATA_W  registered ciphertext.
led_complete  out  1  stream finished.

Behaviour:
- Reset (start_reset_n=0, asynchronous): dout=0, chain_q=0, led_complete=0, state=IDLE.
- Reset asserted mid-stream aborts immediately; there is no partial-completion flag.
- Rotation: rk = rotl(key, shift), a pure rotate. Bits shifted out at the MSB re-enter at the LSB. shift=0 gives rk=key.
- Simple mode: c = din ^ rk.
- Chained mode (improved_encrypt_enable=1, feature built): c = din ^ rk ^ chain_q, and chain_q <= c on the same edge.
- In simple mode chain_q is held, not updated.
- Latency: dout <= c on the rising edge where xor_enable=1. This is 1 cycle from input to output.
- With xor_enable=0, dout holds its last value.
- State IDLE:
  - xor_enable=1 and last_data=0: encrypt, go to RUN.
  - xor_enable=1 and last_data=1: encrypt, go to DONE.
- State RUN:
  - xor_enable=1 and last_data=0: encrypt, stay in RUN.
  - xor_enable=1 and last_data=1: encrypt this final byte, go to DONE.
  - xor_enable=0: go to IDLE (pause). chain_q is kept so the stream can resume.
- State DONE:
  - led_complete=1, registered and asserted from the edge that consumed the last byte.
  - dout and chain_q are frozen; xor_enable and last_data are ignored.
  - Leaving DONE requires reset.
- last_data with xor_enable=0 has no effect.
- Mode may change per byte. Switching from chained to simple does not clear chain_q.
- All arithmetic is bitwise with no carries; outputs are never X after reset.

Optional Feature:
IMPROVED_ENCRYPT_EN
- Defined: chained mode is available, as described above.
- Undefined:
  - improved_encrypt_enable is still a port but is ignored.
  - chain_q is not synthesised; it reads as constant 0.
  - The unit always operates in simple mode.

Decomposition:
- Package xor_encrypter_pkg holds:
  - DATA_W and SHIFT_W defaults.
  - State enum state_t {IDLE, RUN, DONE}.
  - Rotate function rotl(value, amount).
- One sub-module is natural: key_rotator, a combinational barrel rotate of key by shift.
- Top level contains the FSM, the XOR, and the dout/chain_q/led_complete registers.

Test Plan:
- Reset: hold start_reset_n=0 with random inputs -> dout=0x00, led_complete=0. Release, with xor_enable=0 for several cycles -> outputs stay 0.
- Simple sweep: key=0xA8, din=0xFF, xor_enable=1, shift stepped 0,1,2,3,7 one per cycle -> dout=0x57, 0xAE, 0x5D, 0xBA, 0xAB, each one cycle after its shift value is applied.
- Completion: during the sweep, assert last_data=1 with shift=7 -> dout=0xAB, led_complete=1 the same edge. Then change din, key and shift with xor_enable=1 -> dout stays 0xAB and led_complete stays 1 until reset.
- Chained (IMPROVED_ENCRYPT_EN built): key=0xA8, shift=0, din=0xFF for two enabled cycles with improved_encrypt_enable=1 -> dout=0x57, then 0x00. Same stimulus without the macro -> dout=0x57, then 0x57.
- Pause/resume: chained mode, encrypt one byte, drop xor_enable for 3 cycles, re-enable -> dout held during the pause, and chaining continues from the stored chain_q.
- Async reset mid-stream: pull start_reset_n low between clock edges while in RUN -> dout=0 and state=IDLE immediately, without waiting for a clock edge.
